// File: rtl/press_count_rpt.sv
// press_count_rpt: two debounced push-buttons with auto-repeat
// driving a WIDTH-bit up/down counter with wrap or saturate.

module press_count_rpt_ch #(
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pressed,
  output logic step
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW =
    (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int RW =
    (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] H_TOP  = HW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_RATE - 1);
  localparam bit REP_EN = (REPEAT_DELAY > 0);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          prs_q, prs_d;
  logic          dly_q, dly_d;
  logic [DW-1:0] db_q, db_d;
  logic [HW-1:0] h_q, h_d;
  logic [RW-1:0] r_q, r_d;
  logic          at_top;
  logic          rep;

  assign pressed = prs_q;

  // Sync, debounce, saturating hold count and repeat phase
  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
    dly_d  = prs_q;
    prs_d  = prs_q;
    db_d   = '0;
    h_d    = '0;
    r_d    = '0;
    at_top = (h_q == H_TOP);
    if (sync_q != prs_q) begin
      if (db_q == D_LAST) begin
        prs_d = ~prs_q;
      end else begin
        db_d = db_q + 1'b1;
      end
    end
    if (prs_q) begin
      h_d = at_top ? h_q : h_q + 1'b1;
      if (at_top) begin
        r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
      end
    end
    rep  = REP_EN && prs_q && at_top && (r_q == '0);
    step = (prs_q & ~dly_q) | rep;
  end

  // Channel state register
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prs_q  <= 1'b0;
      dly_q  <= 1'b0;
      db_q   <= '0;
      h_q    <= '0;
      r_q    <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prs_q  <= prs_d;
      dly_q  <= dly_d;
      db_q   <= db_d;
      h_q    <= h_d;
      r_q    <= r_d;
    end
  end

endmodule

module press_count_rpt #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int SATURATE     = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             countu,
  input  logic             countd,
  output logic [WIDTH-1:0] nr_presses,
  output logic             pressed_u,
  output logic             pressed_d,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam bit SAT = (SATURATE != 0);

  logic             step_u;
  logic             step_d;
  logic             up_only;
  logic             dn_only;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  press_count_rpt_ch #(
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_ch (
    .clock   (clock),
    .reset   (reset),
    .raw     (countu),
    .pressed (pressed_u),
    .step    (step_u)
  );

  press_count_rpt_ch #(
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) d_ch (
    .clock   (clock),
    .reset   (reset),
    .raw     (countd),
    .pressed (pressed_d),
    .step    (step_d)
  );

  assign up_only    = step_u & ~step_d;
  assign dn_only    = step_d & ~step_u;
  assign nr_presses = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  // Counter next value; coincident steps cancel
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    unique case (1'b1)
      up_only: begin
        ovf_d = (cnt_q == MAX);
        if (!(ovf_d && SAT)) cnt_d = cnt_q + 1'b1;
      end
      dn_only: begin
        unf_d = (cnt_q == '0);
        if (!(unf_d && SAT)) cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Counter and flag register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_press_count_rpt.sv
// tb_press_count_rpt: four configurations of press_count_rpt
// checked every cycle against an edge-indexed behavioural model.

module tb_press_count_rpt;

  localparam int DB   = 4;
  localparam int RATE = 4;
  localparam int NMAX = 8192;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic countu = 1'b0;
  logic countd = 1'b0;

  logic [7:0] nr0, nr1;
  logic [3:0] nr2, nr3;
  logic ov0, ov1, ov2, ov3;
  logic un0, un1, un2, un3;
  logic pu0, pu1, pu2, pu3;
  logic pd0, pd1, pd2, pd3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  press_count_rpt dut0 (
    .clock(clock), .reset(reset),
    .countu(countu), .countd(countd),
    .nr_presses(nr0),
    .pressed_u(pu0), .pressed_d(pd0),
    .overflow(ov0), .underflow(un0)
  );

  press_count_rpt #(.REPEAT_DELAY(0)) dut1 (
    .clock(clock), .reset(reset),
    .countu(countu), .countd(countd),
    .nr_presses(nr1),
    .pressed_u(pu1), .pressed_d(pd1),
    .overflow(ov1), .underflow(un1)
  );

  press_count_rpt #(.WIDTH(4)) dut2 (
    .clock(clock), .reset(reset),
    .countu(countu), .countd(countd),
    .nr_presses(nr2),
    .pressed_u(pu2), .pressed_d(pd2),
    .overflow(ov2), .underflow(un2)
  );

  press_count_rpt #(.WIDTH(4), .SATURATE(1)) dut3 (
    .clock(clock), .reset(reset),
    .countu(countu), .countd(countd),
    .nr_presses(nr3),
    .pressed_u(pu3), .pressed_d(pd3),
    .overflow(ov3), .underflow(un3)
  );

  // Model: raw input recorded per edge; the synchronised
  // level at edge n is the raw value of edge n-2.
  int n_e   = 0;
  int rst_e = -1;
  bit raw_u [NMAX];
  bit raw_d [NMAX];
  bit mp_u  = 1'b0;
  bit mp_d  = 1'b0;
  int t0_u  = 0;
  int t0_d  = 0;
  int m_cnt [4] = '{0, 0, 0, 0};
  bit m_ovf [4] = '{0, 0, 0, 0};
  bit m_unf [4] = '{0, 0, 0, 0};
  int m_w   [4] = '{8, 8, 4, 4};
  int m_del [4] = '{16, 0, 16, 16};
  bit m_sat [4] = '{0, 0, 0, 1};

  logic [39:0] obs;
  logic [39:0] exp_v;

  assign obs = {nr0, ov0, un0, pu0, pd0,
                nr1, ov1, un1, pu1, pd1,
                nr2, ov2, un2, pu2, pd2,
                nr3, ov3, un3, pu3, pd3};

  assign exp_v = {m_cnt[0][7:0], m_ovf[0], m_unf[0], mp_u, mp_d,
                  m_cnt[1][7:0], m_ovf[1], m_unf[1], mp_u, mp_d,
                  m_cnt[2][3:0], m_ovf[2], m_unf[2], mp_u, mp_d,
                  m_cnt[3][3:0], m_ovf[3], m_unf[3], mp_u, mp_d};

  function automatic bit s_at(input bit ch, input int idx);
    if (idx < 0 || idx <= rst_e || idx >= NMAX) return 1'b0;
    return ch ? raw_d[idx] : raw_u[idx];
  endfunction

  // Level accepted once the last DB synced samples all differ.
  function automatic bit flips(input bit ch, input bit p);
    for (int i = 0; i < DB; i++)
      if (s_at(ch, n_e - 2 - i) == p) return 1'b0;
    return 1'b1;
  endfunction

  // Step when held h cycles: h=0, or h=del+k*RATE.
  function automatic bit stepf(input bit p, input int t0,
                               input int del);
    int h;
    h = n_e - 1 - t0;
    if (!p) return 1'b0;
    if (h == 0) return 1'b1;
    return del > 0 && h >= del && ((h - del) % RATE) == 0;
  endfunction

  task automatic model_step();
    bit su, sd;
    int mx;
    if (reset) begin
      rst_e = n_e;
      mp_u  = 1'b0;
      mp_d  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        su = stepf(mp_u, t0_u, m_del[k]);
        sd = stepf(mp_d, t0_d, m_del[k]);
        mx = (1 << m_w[k]) - 1;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
        if (su && !sd) begin
          m_ovf[k] = (m_cnt[k] == mx);
          if (m_cnt[k] == mx) m_cnt[k] = m_sat[k] ? mx : 0;
          else m_cnt[k] = m_cnt[k] + 1;
        end else if (sd && !su) begin
          m_unf[k] = (m_cnt[k] == 0);
          if (m_cnt[k] == 0) m_cnt[k] = m_sat[k] ? 0 : mx;
          else m_cnt[k] = m_cnt[k] - 1;
        end
      end
      if (flips(1'b0, mp_u)) begin
        mp_u = ~mp_u;
        if (mp_u) t0_u = n_e;
      end
      if (flips(1'b1, mp_d)) begin
        mp_d = ~mp_d;
        if (mp_d) t0_d = n_e;
      end
      if (n_e < NMAX) begin
        raw_u[n_e] = countu;
        raw_d[n_e] = countd;
      end
    end
    n_e++;
  endtask

  task automatic cyc(input logic r, input logic u,
                     input logic d);
    @(negedge clock);
    reset  = r;
    countu = u;
    countd = d;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    n_tests++;
    if (obs !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_model: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_single_press();
    int hi = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      cyc(1'b0, e <= 5, 1'b0);
      hi += int'(pu0);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_e%0d: got %h want %h",
                 e, obs, exp_v);
      end
      if (e == 6) begin
        n_tests++;
        if (nr0 !== 8'd0) begin
          n_fail++;
          $display("FAIL single_edge6: got %0d want 0", nr0);
        end
      end
      if (e == 7) begin
        n_tests++;
        if (nr0 !== 8'd1) begin
          n_fail++;
          $display("FAIL single_edge7: got %0d want 1", nr0);
        end
      end
    end
    n_tests++;
    if (hi != 5) begin
      n_fail++;
      $display("FAIL single_width: got %0d want 5", hi);
    end
    n_tests++;
    if (nr0 !== 8'd1) begin
      n_fail++;
      $display("FAIL single_final: got %0d want 1", nr0);
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    logic u;
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 80; c++) begin
      u = (c == 10) || (c >= 20 && c < 22) ||
          (c >= 32 && c < 35);
      cyc(1'b0, u, 1'b0);
      seen |= pu0;
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL glitch_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (seen !== 1'b0 || nr0 !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_reject: pressed=%b nr=%0d want 0 0",
               seen, nr0);
    end
    for (int c = 0; c < 30; c++) begin
      u = (c == 0) || (c == 2) || (c >= 4 && c < 14);
      cyc(1'b0, u, 1'b0);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bounce_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (nr0 !== 8'd1) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d want 1", nr0);
    end
  endtask

  task automatic test_repeat();
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) begin
      cyc(1'b0, c < 30, 1'b0);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL repeat_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (nr0 !== 8'd5 || nr1 !== 8'd1) begin
      n_fail++;
      $display("FAIL repeat_total: got %0d/%0d want 5/1",
               nr0, nr1);
    end
  endtask

  task automatic test_wrap_sat();
    int ovc2 = 0;
    int ovc3 = 0;
    int unc2 = 0;
    int unc3 = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 16 * 13; c++) begin
      cyc(1'b0, (c % 13) < 5, 1'b0);
      if (c >= 15 * 13) begin
        ovc2 += int'(ov2);
        ovc3 += int'(ov3);
      end
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
      if (c == 15 * 13 - 1) begin
        n_tests++;
        if (nr2 !== 4'd15 || nr3 !== 4'd15) begin
          n_fail++;
          $display("FAIL wrap_at15: got %0d/%0d want 15/15",
                   nr2, nr3);
        end
      end
    end
    n_tests++;
    if (nr2 !== 4'd0 || nr3 !== 4'd15 || nr0 !== 8'd16) begin
      n_fail++;
      $display("FAIL wrap_after: got %0d/%0d/%0d want 0/15/16",
               nr2, nr3, nr0);
    end
    n_tests++;
    if (ovc2 != 1 || ovc3 != 1) begin
      n_fail++;
      $display("FAIL wrap_ovf_pulse: got %0d/%0d want 1/1",
               ovc2, ovc3);
    end
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 13; c++) begin
      cyc(1'b0, 1'b0, c < 5);
      unc2 += int'(un2);
      unc3 += int'(un3);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL under_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (nr2 !== 4'd15 || nr3 !== 4'd0 || nr0 !== 8'd255) begin
      n_fail++;
      $display("FAIL under_val: got %0d/%0d/%0d want 15/0/255",
               nr2, nr3, nr0);
    end
    n_tests++;
    if (unc2 != 1 || unc3 != 1) begin
      n_fail++;
      $display("FAIL under_pulse: got %0d/%0d want 1/1",
               unc2, unc3);
    end
  endtask

  task automatic test_simul();
    int flags = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, c < 5, c < 5);
      flags += int'(ov0 | un0 | ov2 | un2 | ov3 | un3);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL simul_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (nr0 !== 8'd0 || flags != 0) begin
      n_fail++;
      $display("FAIL simul_cancel: got nr=%0d flags=%0d want 0 0",
               nr0, flags);
    end
    for (int c = 0; c < 60; c++) begin
      cyc(1'b0, c >= 16 && c < 21, c < 40);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL overlap_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (nr0 !== 8'd250 || nr1 !== 8'd0 ||
        nr2 !== 4'd10 || nr3 !== 4'd0) begin
      n_fail++;
      $display("FAIL overlap_net: got %0d/%0d/%0d/%0d want 250/0/10/0",
               nr0, nr1, nr2, nr3);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] prev;
    int nseen = 0;
    int f0 = -1;
    int f1 = -1;
    int f2 = -1;
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 39; c++) begin
      cyc(1'b0, (c % 13) < 5, 1'b0);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rmid_pre_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    n_tests++;
    if (nr0 !== 8'd3) begin
      n_fail++;
      $display("FAIL rmid_three: got %0d want 3", nr0);
    end
    for (int c = 0; c < 26; c++) begin
      cyc(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rmid_hold_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
    cyc(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (obs !== 40'd0) begin
      n_fail++;
      $display("FAIL rmid_cleared: got %h want 0", obs);
    end
    prev = nr0;
    for (int k = 1; k <= 35; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (nr0 !== prev) begin
        if (nseen == 0) f0 = k;
        if (nseen == 1) f1 = k;
        if (nseen == 2) f2 = k;
        nseen++;
      end
      prev = nr0;
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rmid_post_k%0d: got %h want %h",
                 k, obs, exp_v);
      end
    end
    n_tests++;
    if (f0 != DB + 3 || f1 != DB + 19 || f2 != DB + 23) begin
      n_fail++;
      $display("FAIL rmid_timing: got %0d/%0d/%0d want %0d/%0d/%0d",
               f0, f1, f2, DB + 3, DB + 19, DB + 23);
    end
  endtask

  task automatic test_random();
    logic lu = 1'b0;
    logic ld = 1'b0;
    logic r;
    int ru = 0;
    int rd = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      if (ru == 0) begin
        lu = ~lu;
        ru = ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, 3)) :
             int'($urandom_range(4, 45));
      end
      if (rd == 0) begin
        ld = ~ld;
        rd = ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, 3)) :
             int'($urandom_range(4, 45));
      end
      ru--;
      rd--;
      r = ($urandom_range(0, 399) == 0);
      cyc(r, lu, ld);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h want %h",
                 c, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_wrap_sat();
    test_simul();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/press_count_rpt.md
Name: press_count_rpt

Overview:
Parametrised successor to the basic up/down press counter. Two raw, asynchronous, bouncy push-button inputs each pass through a synchroniser and a debounce filter, then an edge/auto-repeat generator, and drive a WIDTH-bit up/down counter. Counter overflow is selectable as wrap or saturate, with one-cycle over/underflow flags. Sits between the board button pins and the display/control logic.

Parameters:
WIDTH, 8, counter width in bits (>=2)
DEBOUNCE, 4, consecutive stable cycles needed to accept a level change (>=1)
REPEAT_DELAY, 16, cycles a debounced press must be held before the first auto-repeat step; 0 disables auto-repeat
REPEAT_RATE, 4, cycles between subsequent auto-repeat steps (>=1; ignored if REPEAT_DELAY=0)
SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at 0 / 2^WIDTH-1

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
countu  in  1  raw count-up button, asynchronous, may bounce
countd  in  1  raw count-down button, asynchronous, may bounce
nr_presses  out  WIDTH  current count
pressed_u  out  1  debounced level of countu
pressed_d  out  1  debounced level of countd
overflow  out  1  one-cycle pulse: an up step occurred at 2^WIDTH-1
underflow  out  1  one-cycle pulse: a down step occurred at 0

Behaviour:
- Reset is synchronous and active-high: it clears the sync flops, debounce counters, hold counters and nr_presses to 0, and drives pressed_u, pressed_d, overflow and underflow to 0. A reset asserted mid-hold or mid-debounce discards all progress. After reset, a button still physically held counts as a fresh press, subject to the full latency.
- Per channel (u, d are identical and independent):
  - Sync: 2-flop synchroniser; s = second flop.
  - Debounce: the counter increments on each cycle where s != pressed and clears whenever s == pressed. When the counter reaches DEBOUNCE, pressed toggles and the counter clears. Glitches shorter than DEBOUNCE cycles are invisible.
  - Latency: count the first rising edge that samples the raw input at its new level as edge 1. pressed changes at edge 2+DEBOUNCE. The resulting count update occurs at edge 3+DEBOUNCE. Rise and fall latencies are identical, so pressed stays high exactly as many cycles as a clean raw pulse.
  - Step generation: step = pressed & ~pressed_q (initial step). Hold counter h is 0 in the cycle of the initial step and increments each cycle while pressed=1.
  - With REPEAT_DELAY>0, further steps occur at h = REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, REPEAT_DELAY+2*REPEAT_RATE, and so on. h saturates internally: the implementation wraps its phase and must not overflow.
  - Release (pressed=0) clears h immediately. No step is generated on release.
- Counter update (registered, one edge after the step cycle):
  - step_u only: nr_presses+1. At the maximum value: wrap to 0 (SATURATE=0) or hold (SATURATE=1). overflow pulses in either mode.
  - step_d only: nr_presses-1. At 0: wrap to max or hold. underflow pulses in either mode.
  - step_u and step_d in the same cycle: no change, no flags.
  - No step: hold; overflow and underflow are 0.
- overflow and underflow are asserted in exactly the cycle that nr_presses takes the post-step value.
- Holding one button does not block the other. Steps from both channels in the same cycle cancel per the rule above.

Test Plan:
1. Defaults (WIDTH=8, DEBOUNCE=4, REPEAT_DELAY=16, REPEAT_RATE=4). Reset, then clean countu high for 5 cycles -> nr_presses goes 0->1 at edge 7 after the sampling edge; pressed_u is high for exactly 5 cycles; no further change.
2. Glitch rejection: countu pulses of 1, 2 and 3 cycles, spaced 10 cycles apart -> nr_presses stays 0, pressed_u never rises. A bouncing edge (1/0/1/0, then stable high 10 cycles) -> exactly +1.
3. Auto-repeat: clean countu high for 30 cycles -> steps at hold offsets 0, 16, 20, 24, 28 -> nr_presses = 5. Same test with REPEAT_DELAY=0 -> nr_presses = 1.
4. Wrap vs saturate (WIDTH=4): 15 presses then 1 more with SATURATE=0 -> 15->0 with a 1-cycle overflow pulse in that cycle. Same with SATURATE=1 -> stays 15, overflow still pulses. From 0, one countd press -> 15 with underflow (wrap), or 0 with underflow (saturate).
5. Simultaneous: countu and countd rise in the same cycle and are held 5 cycles -> nr_presses unchanged, no flags. countd held in repeat while countu is pressed once -> net count reflects cancellation only in the coincident cycle.
6. Reset mid-operation: with nr_presses=3 and countu held in repeat, assert reset for 1 cycle -> next edge all outputs 0. With countu still held, the first increment occurs DEBOUNCE+3 edges after reset deasserts (a new press), followed by repeats at +16 and +20.
